// File: rtl/cmp_minmax_ctrl_pkg.sv
// Shared definitions for cmp_minmax_ctrl: sequencer state encodings.
package cmp_minmax_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CMP_MAX = 3'd2,
        ST_CMP_MIN = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/cmp_minmax_ctrl_comparator.sv
// Unsigned magnitude comparator shared by the min/max sequencer.
module cmp_minmax_ctrl_comparator #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b,
    output logic             a_lt_b
);

    assign a_gt_b = (a > b);
    assign a_lt_b = (a < b);

endmodule

// File: rtl/cmp_minmax_ctrl.sv
// Finds min/max of a COUNT-sample burst by time-sharing one comparator.
// Define ARGIDX_EN to add first-occurrence index outputs min_idx/max_idx.
module cmp_minmax_ctrl
    import cmp_minmax_ctrl_pkg::*;
#(
    parameter int  WIDTH = 4,
    parameter int  COUNT = 8,
    localparam int IDX_W = $clog2(COUNT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] min_val,
    output logic [WIDTH-1:0] max_val
`ifdef ARGIDX_EN
    ,
    output logic [IDX_W-1:0] min_idx,
    output logic [IDX_W-1:0] max_idx
`endif
);

    localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(COUNT - 1);
    localparam logic [IDX_W:0] ONE_CNT  = (IDX_W+1)'(1);

    state_t           state;
    state_t           next_state;
    logic [IDX_W:0]   count;
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] cmp_b;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             take;
    logic             first;
    logic             last;

    assign take  = in_valid && (state == ST_WAIT);
    assign first = (count == '0);
    assign last  = (count == LAST_CNT);

    // Moore outputs decoded straight from the state register.
    assign in_ready = (state == ST_WAIT);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    // The single comparator: B follows whichever running result is being tested.
    assign cmp_b = (state == ST_CMP_MIN) ? min_val : max_val;

    cmp_minmax_ctrl_comparator #(
        .WIDTH (WIDTH)
    ) u_comparator (
        .a      (hold),
        .b      (cmp_b),
        .a_gt_b (a_gt_b),
        .a_lt_b (a_lt_b)
    );

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            ST_IDLE:    if (start) next_state = ST_WAIT;
            ST_WAIT:    if (take && !first) next_state = ST_CMP_MAX;
            ST_CMP_MAX: next_state = ST_CMP_MIN;
            ST_CMP_MIN: next_state = last ? ST_DONE : ST_WAIT;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Results survive start and are only overwritten once sample 0 arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            hold    <= '0;
            min_val <= '0;
            max_val <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) count <= '0;
                end
                ST_WAIT: begin
                    if (take) begin
                        if (first) begin
                            min_val <= in_data;
                            max_val <= in_data;
                            count   <= ONE_CNT;
                        end else begin
                            hold <= in_data;
                        end
                    end
                end
                ST_CMP_MAX: begin
                    if (a_gt_b) max_val <= hold;
                end
                ST_CMP_MIN: begin
                    if (a_lt_b) min_val <= hold;
                    count <= count + ONE_CNT;
                end
                default: ;
            endcase
        end
    end

`ifdef ARGIDX_EN
    // Strict compares only, so a tie keeps the index of the first occurrence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_idx <= '0;
            max_idx <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (take && first) begin
                        min_idx <= '0;
                        max_idx <= '0;
                    end
                end
                ST_CMP_MAX: if (a_gt_b) max_idx <= count[IDX_W-1:0];
                ST_CMP_MIN: if (a_lt_b) min_idx <= count[IDX_W-1:0];
                default: ;
            endcase
        end
    end
`endif

endmodule
